// File: rtl/jtag_scan_master.sv
// jtag_scan_master: sequences IR/DR scans through an IEEE 1149.1 TAP from Run-Test/Idle and back.
// Ports:
//   TCK, TRST          clock and synchronous active-high reset (re-runs the TAP reset sequence)
//   cmd_valid/ready    scan request handshake, accepted only in IDLE
//   cmd_ir/len/data    scan type, length in bits (clamped to MAX_LEN), TDI bits LSB first
//   TDO                serial data returned by the TAP
//   TMS, TDI           registered TAP drive
//   rsp_valid/data     one-cycle completion strobe and captured TDO bits (first bit in bit 0)
module jtag_scan_master #(
   parameter int MAX_LEN = 32
) (
   input  logic               TCK,
   input  logic               TRST,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic               cmd_ir,
   input  logic [5:0]         cmd_len,
   input  logic [MAX_LEN-1:0] cmd_data,
   input  logic               TDO,
   output logic               TMS,
   output logic               TDI,
   output logic               rsp_valid,
   output logic [MAX_LEN-1:0] rsp_data
);
   typedef enum logic [3:0] {
      RST_SEQ, GO_IDLE, IDLE, SEL_DR, SEL_IR, CAPTURE, SHIFT, EXIT1, UPDATE, DONE
   } state_t;
   state_t             state_q, state_d;
   logic [2:0]         rst_cnt_q, rst_cnt_d;
   logic [5:0]         cnt_q, cnt_d, len_q, len_d, len_eff;
   logic               cap_q, cap_d, ir_q, ir_d;
   logic [MAX_LEN-1:0] data_q, data_d, tdo_q, tdo_d, rsp_q, rsp_d;
   logic               tms_q, tms_d, tdi_q, tdi_d, ready_q, valid_q;
   assign len_eff   = (32'(cmd_len) > MAX_LEN) ? 6'(MAX_LEN) : cmd_len;
   assign cmd_ready = ready_q;
   assign TMS       = tms_q;
   assign TDI       = tdi_q;
   assign rsp_valid = valid_q;
   assign rsp_data  = rsp_q;
   // Each state names the TAP transition driven during that cycle. CAPTURE spans two
   // cycles (Select->Capture, Capture->Shift); SHIFT spans L cycles, its last one moving to Exit1.
   always_comb begin
      state_d   = state_q;
      rst_cnt_d = rst_cnt_q;
      cnt_d     = cnt_q;
      cap_d     = cap_q;
      len_d     = len_q;
      ir_d      = ir_q;
      data_d    = data_q;
      tdo_d     = tdo_q;
      case (state_q)
         RST_SEQ: begin
            state_d   = (rst_cnt_q == 3'd4) ? GO_IDLE : RST_SEQ;
            rst_cnt_d = (rst_cnt_q == 3'd4) ? 3'd0 : rst_cnt_q + 3'd1;
         end
         GO_IDLE: state_d = IDLE;
         IDLE: if (cmd_valid) begin
            ir_d    = cmd_ir;
            len_d   = len_eff;
            data_d  = cmd_data;
            tdo_d   = '0;
            cnt_d   = '0;
            state_d = (len_eff == 6'd0) ? DONE : SEL_DR;
         end
         SEL_DR: begin
            state_d = ir_q ? SEL_IR : CAPTURE;
            cap_d   = 1'b0;
         end
         SEL_IR: begin
            state_d = CAPTURE;
            cap_d   = 1'b0;
         end
         CAPTURE: begin
            cap_d   = 1'b1;
            state_d = cap_q ? SHIFT : CAPTURE;
            cnt_d   = '0;
         end
         SHIFT: begin
            tdo_d = tdo_q | ({{(MAX_LEN-1){1'b0}}, TDO} << cnt_q);
            if (cnt_q == len_q - 6'd1) state_d = EXIT1;
            else cnt_d = cnt_q + 6'd1;
         end
         EXIT1:   state_d = UPDATE;
         UPDATE:  state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = RST_SEQ;
      endcase
      // Outputs are registered, so they are derived from the state being entered.
      tms_d = (state_d == SHIFT) ? (cnt_d == len_q - 6'd1)
                                 : (state_d inside {RST_SEQ, SEL_DR, SEL_IR, EXIT1});
      tdi_d = (state_d == SHIFT) && data_q[0];
      if (state_d == SHIFT) data_d = data_q >> 1;
      rsp_d = (state_d == DONE) ? tdo_d : rsp_q;
   end
   always_ff @(posedge TCK) begin
      if (TRST) begin
         state_q   <= RST_SEQ;
         rst_cnt_q <= '0;
         cnt_q     <= '0;
         cap_q     <= 1'b0;
         len_q     <= '0;
         ir_q      <= 1'b0;
         data_q    <= '0;
         tdo_q     <= '0;
         rsp_q     <= '0;
         tms_q     <= 1'b1;
         tdi_q     <= 1'b0;
         ready_q   <= 1'b0;
         valid_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         rst_cnt_q <= rst_cnt_d;
         cnt_q     <= cnt_d;
         cap_q     <= cap_d;
         len_q     <= len_d;
         ir_q      <= ir_d;
         data_q    <= data_d;
         tdo_q     <= tdo_d;
         rsp_q     <= rsp_d;
         tms_q     <= tms_d;
         tdi_q     <= tdi_d;
         ready_q   <= (state_d == IDLE);
         valid_q   <= (state_d == DONE);
      end
   end
endmodule

// File: tb/tb_jtag_scan_master.sv
// tb_jtag_scan_master: directed and randomized scans checked against a TMS/TDI/TDO sequence model.
module tb_jtag_scan_master;
   logic        TCK, TRST, cmd_valid, cmd_ready, cmd_ir, TDO, TMS, TDI, rsp_valid;
   logic [5:0]  cmd_len;
   logic [31:0] cmd_data, rsp_data, last_rsp, d;
   bit          exp_tms[$];
   bit          exp_tdi[$];
   int          exp_k[$];
   int          checks, failures;
   jtag_scan_master #(.MAX_LEN(32)) dut (
      .TCK(TCK), .TRST(TRST), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_ir(cmd_ir), .cmd_len(cmd_len), .cmd_data(cmd_data), .TDO(TDO),
      .TMS(TMS), .TDI(TDI), .rsp_valid(rsp_valid), .rsp_data(rsp_data)
   );
   initial TCK = 1'b0;
   always #5 TCK = ~TCK;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   function automatic void push(input bit tms, input bit tdi, input int k);
      exp_tms.push_back(tms);
      exp_tdi.push_back(tdi);
      exp_k.push_back(k);
   endfunction
   // Cycle-by-cycle expectation after acceptance: walk Idle->Select(-IR)->Capture->Shift,
   // shift L bits (last one leaves Shift), then Exit1->Update->Idle.
   function automatic void build(input logic ir, input logic [5:0] len, input logic [31:0] data);
      int l;
      l = (int'(len) > 32) ? 32 : int'(len);
      exp_tms.delete();
      exp_tdi.delete();
      exp_k.delete();
      if (l == 0) return;
      push(1, 0, -1);
      if (ir) push(1, 0, -1);
      push(0, 0, -1);
      push(0, 0, -1);
      for (int k = 0; k < l; k++) push(k == l - 1, data[k], k);
      push(1, 0, -1);
      push(0, 0, -1);
   endfunction
   task automatic do_reset(input int hold);
      TRST = 1'b1;
      repeat (hold) @(negedge TCK);
      chk("rst_tdi", 32'(TDI), 32'd0);
      chk("rst_rsp_data", rsp_data, 32'd0);
      TRST = 1'b0;
      last_rsp = '0;
      for (int i = 0; i < 5; i++) begin
         if (i > 0) @(negedge TCK);
         chk($sformatf("rst_seq_tms[%0d]", i), 32'(TMS), 32'd1);
         chk($sformatf("rst_seq_ready[%0d]", i), 32'(cmd_ready), 32'd0);
         chk($sformatf("rst_seq_valid[%0d]", i), 32'(rsp_valid), 32'd0);
      end
      @(negedge TCK);
      chk("go_idle_tms", 32'(TMS), 32'd0);
      chk("go_idle_ready", 32'(cmd_ready), 32'd0);
      @(negedge TCK);
      chk("idle_ready", 32'(cmd_ready), 32'd1);
      chk("idle_tms", 32'(TMS), 32'd0);
      chk("idle_valid", 32'(rsp_valid), 32'd0);
   endtask
   task automatic wait_ready();
      int n;
      n = 0;
      while (cmd_ready !== 1'b1 && n < 20) begin
         @(negedge TCK);
         n++;
      end
      chk("accept_ready", 32'(cmd_ready), 32'd1);
   endtask
   // mode: 0 TDO tied 0, 1 tied 1, 2 looped from TDI, 3 random per cycle
   task automatic scan(input logic ir, input logic [5:0] len, input logic [31:0] data,
                       input int mode, input bit hold_next);
      logic [31:0] exp_rsp;
      logic        t;
      build(ir, len, data);
      wait_ready();
      cmd_valid = 1'b1;
      cmd_ir    = ir;
      cmd_len   = len;
      cmd_data  = data;
      @(negedge TCK);
      cmd_valid = 1'b0;
      cmd_ir    = 1'($urandom);
      cmd_len   = 6'($urandom);
      cmd_data  = $urandom;
      exp_rsp   = '0;
      for (int i = 0; i < exp_tms.size(); i++) begin
         t = (mode == 0) ? 1'b0 : (mode == 1) ? 1'b1 : (mode == 2) ? exp_tdi[i] : 1'($urandom);
         TDO = t;
         if (exp_k[i] >= 0) exp_rsp[exp_k[i]] = t;
         chk($sformatf("tms[%0d]", i), 32'(TMS), 32'(exp_tms[i]));
         chk($sformatf("tdi[%0d]", i), 32'(TDI), 32'(exp_tdi[i]));
         chk($sformatf("busy_valid[%0d]", i), 32'(rsp_valid), 32'd0);
         chk($sformatf("busy_ready[%0d]", i), 32'(cmd_ready), 32'd0);
         chk($sformatf("hold_rsp[%0d]", i), rsp_data, last_rsp);
         @(negedge TCK);
      end
      chk("done_valid", 32'(rsp_valid), 32'd1);
      chk("done_rsp_data", rsp_data, exp_rsp);
      chk("done_tms", 32'(TMS), 32'd0);
      chk("done_tdi", 32'(TDI), 32'd0);
      chk("done_ready", 32'(cmd_ready), 32'd0);
      last_rsp = exp_rsp;
      if (hold_next) cmd_valid = 1'b1;
      @(negedge TCK);
      chk("after_valid", 32'(rsp_valid), 32'd0);
      chk("after_ready", 32'(cmd_ready), 32'd1);
      chk("after_rsp_data", rsp_data, last_rsp);
      chk("after_tms", 32'(TMS), 32'd0);
   endtask
   initial begin
      checks    = 0;
      failures  = 0;
      last_rsp  = '0;
      TRST      = 1'b1;
      cmd_valid = 1'b0;
      cmd_ir    = 1'b0;
      cmd_len   = '0;
      cmd_data  = '0;
      TDO       = 1'b0;
      do_reset(2);
      scan(1'b0, 6'd8, 32'h0000_00A5, 1, 1'b0);
      scan(1'b1, 6'd4, 32'h0000_0003, 0, 1'b0);
      scan(1'b0, 6'd32, 32'hDEAD_BEEF, 2, 1'b1);
      scan(1'b0, 6'd0, $urandom, 3, 1'b1);
      scan(1'b1, 6'd40, $urandom, 2, 1'b0);
      scan(1'b0, 6'd1, $urandom, 1, 1'b0);
      d = $urandom;
      build(1'b0, 6'd16, d);
      wait_ready();
      cmd_valid = 1'b1;
      cmd_ir    = 1'b0;
      cmd_len   = 6'd16;
      cmd_data  = d;
      @(negedge TCK);
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("abort_tms[%0d]", i), 32'(TMS), 32'(exp_tms[i]));
         chk($sformatf("abort_tdi[%0d]", i), 32'(TDI), 32'(exp_tdi[i]));
         chk($sformatf("abort_ready[%0d]", i), 32'(cmd_ready), 32'd0);
         if (i < 7) @(negedge TCK);
      end
      do_reset(1);
      scan(1'b0, 6'd16, $urandom, 3, 1'b0);
      for (int r = 0; r < 10; r++)
         scan(1'($urandom), 6'($urandom_range(0, 45)), $urandom, int'($urandom_range(0, 3)),
              (r < 9) && ($urandom_range(0, 1) == 1));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/jtag_scan_master.md
JTAG_SCAN_MASTER -- requirements
Module: jtag_scan_master

Interface
REQ-001 The block SHALL have parameter MAX_LEN, default 32, giving the maximum scan length in bits and the width of cmd_data and rsp_data.
REQ-002 The block SHALL have these ports, one clock and one reset:
- TCK  in  1  sole clock; all state changes on posedge.
- TRST  in  1  reset, synchronous, active-high.
- cmd_valid  in  1  scan request.
- cmd_ready  out  1  sequencer can accept a request.
- cmd_ir  in  1  1 = IR scan, 0 = DR scan.
- cmd_len  in  6  scan length in bits.
- cmd_data  in  MAX_LEN  TDI bits, LSB shifted first.
- TDO  in  1  serial data from the TAP.
- TMS  out  1  TAP mode select, registered.
- TDI  out  1  TAP serial data, registered.
- rsp_valid  out  1  one-cycle scan-complete strobe.
- rsp_data  out  MAX_LEN  captured TDO bits, first captured bit in bit 0.

Function
REQ-003 The block SHALL use states RST_SEQ, GO_IDLE, IDLE, SEL_DR, SEL_IR, CAPTURE, SHIFT, EXIT1, UPDATE and DONE.
REQ-004 A request SHALL be accepted on a posedge where cmd_valid && cmd_ready; cmd_ir, cmd_len and cmd_data SHALL be latched at that edge.
REQ-005 cmd_ready SHALL be 1 only in IDLE, and cmd_valid SHALL be ignored in every other state.
REQ-006 The block SHALL clamp an effective length L to MAX_LEN when cmd_len > MAX_LEN.
REQ-007 When cmd_len = 0, the block SHALL skip TAP traffic: TMS stays 0, the next cycle is DONE, and rsp_data = 0.
REQ-008 After DR acceptance, TMS presented on consecutive cycles SHALL be: 1 (SEL_DR), 0 (CAPTURE), 0 (enter SHIFT), L shift cycles, 1 (UPDATE), 0 (to IDLE). Total is L+5 cycles.
REQ-009 IR scans SHALL present the same TMS sequence as DR scans with an extra leading 1 (SEL_DR then SEL_IR), for a total of L+6 cycles.
REQ-010 During shift cycles, TMS SHALL be 0 for the first L-1 cycles and 1 on the last cycle, so the TAP moves to Exit1 while shifting the final bit.
REQ-011 In the k-th shift cycle (k = 0..L-1), TDI SHALL equal latched cmd_data[k]; outside shift cycles TDI SHALL be 0.
REQ-012 TDO SHALL be sampled on the posedge that ends the k-th shift cycle and stored in rsp_data[k]. Bits L..MAX_LEN-1 of rsp_data SHALL be 0.
REQ-013 rsp_data SHALL hold its value from DONE until the next DONE.
REQ-014 rsp_valid SHALL be 1 for exactly one cycle in DONE, with no backpressure. DONE SHALL return to IDLE on the next edge.
REQ-015 Back-to-back requests SHALL be supported: a request presented during DONE SHALL be accepted one cycle later, in IDLE.
REQ-016 A shift counter SHALL count 0..L-1 with no wrap-around. The last-bit condition is counter = L-1.

Reset
REQ-017 While TRST = 1 at a posedge, the next state SHALL be: TMS = 1, TDI = 0, cmd_ready = 0, rsp_valid = 0, rsp_data = 0, state RST_SEQ, counters 0.
REQ-018 After TRST deasserts, RST_SEQ SHALL hold TMS = 1 for 5 cycles, GO_IDLE SHALL present TMS = 0 for 1 cycle, and then IDLE SHALL assert cmd_ready = 1.
REQ-019 TRST asserted mid-scan SHALL abort the scan, produce no rsp_valid, and restart the full REQ-018 sequence after release.
REQ-020 In IDLE, TMS SHALL be held 0 so the TAP remains in Run-Test/Idle.

Verification
REQ-021 Reset: TRST high 2 cycles then low -> TMS = 1 for 5 cycles, TMS = 0, then cmd_ready = 1; rsp_valid stays 0 throughout.
REQ-022 DR scan: cmd_ir = 0, cmd_len = 8, cmd_data = 0xA5, TDO tied 1 ->
- TMS = 1,0,0,0,0,0,0,0,0,0,1,1,0;
- TDI in shift cycles = 1,0,1,0,0,1,0,1;
- rsp_valid on the 14th cycle after acceptance, rsp_data = 0x000000FF.
REQ-023 IR scan: cmd_ir = 1, cmd_len = 4, cmd_data = 0x3, TDO tied 0 -> TMS = 1,1,0,0,0,0,0,1,1,0; rsp_data = 0.
REQ-024 Full width: cmd_len = 32, cmd_data = 0xDEADBEEF, TDO looped from TDI -> rsp_data = 0xDEADBEEF.
REQ-025 Length boundaries:
- cmd_len = 0 -> TMS stays 0, rsp_valid the cycle after acceptance, rsp_data = 0.
- cmd_len = 40 -> exactly 32 shift cycles.
REQ-026 TRST pulsed at the 5th shift cycle of a 16-bit scan -> TMS = 1 next cycle, no rsp_valid, REQ-018 sequence repeated. A request held asserted during the scan is accepted only once IDLE is reached.
